// File: rtl/arilla_timer_pkg.sv
// Shared constants for the Arilla machine timer: register offsets, CTRL layout, reset values.
package arilla_timer_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 30;
    localparam int WIN_WORDS = 8;

    typedef enum logic [2:0] {
        TIMER_MTIME_LO    = 3'd0,
        TIMER_MTIME_HI    = 3'd1,
        TIMER_MTIMECMP_LO = 3'd2,
        TIMER_MTIMECMP_HI = 3'd3,
        TIMER_CTRL        = 3'd4,
        TIMER_MSIP        = 3'd5
    } timer_off_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 16;

    localparam logic [63:0]       MTIME_RST    = 64'h0;
    localparam logic [63:0]       MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [DATA_W-1:0] CTRL_RST     = '0;

    // Writable CTRL bits: EN plus the DIV field; everything else reads back as 0.
    function automatic logic [DATA_W-1:0] ctrl_wmask(input int unsigned pw);
        logic [DATA_W-1:0] m;
        m = '0;
        m[CTRL_EN_BIT] = 1'b1;
        for (int i = 0; i < DATA_W - CTRL_DIV_LSB; i++)
            if (i < int'(pw)) m[CTRL_DIV_LSB + i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/arilla_timer_if.sv
// Arilla system bus: initiator drives data_ctp/address/strobes, responder drives data_ptc/available.
interface arilla_bus_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 30
);
    logic [DataWidth-1:0]   data_ctp;
    logic [DataWidth-1:0]   data_ptc;
    logic [AddrWidth-1:0]   address;
    logic [DataWidth/8-1:0] byte_enable;
    logic                   read;
    logic                   write;
    logic                   intercept;
    logic                   available;

    modport master (
        output data_ctp, address, byte_enable, read, write, intercept,
        input  data_ptc, available
    );

    modport slave (
        input  data_ctp, address, byte_enable, read, write, intercept,
        output data_ptc, available
    );
endinterface

// File: rtl/arilla_be_reg.sv
// Register with byte-lane write merge; a bus write takes priority over the internal update.
module arilla_be_reg #(
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] ResetVal  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic                   upd_i,
    input  logic [DataWidth-1:0]   nxt_i,
    output logic [DataWidth-1:0]   q_o
);
    logic [DataWidth-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we_i) begin
            for (int i = 0; i < DataWidth/8; i++)
                if (be_i[i]) q_d[8*i +: 8] = wdata_i[8*i +: 8];
        end else if (upd_i) begin
            q_d = nxt_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= ResetVal;
        else     q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

// File: rtl/arilla_timer.sv
// RISC-V machine timer on the Arilla bus: mtime/mtimecmp/CTRL with prescaled tick and timer_irq.
// Define ARILLA_TIMER_MSIP_EN to add the MSIP register at offset 5 and the soft_irq output.
module arilla_timer
    import arilla_timer_pkg::*;
#(
    parameter int          DataWidth     = 32,
    parameter logic [31:0] BaseAddress   = 32'h0200_0000,
    parameter int          PrescaleWidth = 16
) (
    input  logic         clk,
    input  logic         rst,
    arilla_bus_if.slave  bus,
`ifdef ARILLA_TIMER_MSIP_EN
    output logic         soft_irq,
`endif
    output logic         timer_irq
);
    localparam logic [ADDR_W-1:0]    BASE_WORD = BaseAddress[31:2];
    localparam logic [DataWidth-1:0] CTRL_MASK = ctrl_wmask(PrescaleWidth);

    logic [ADDR_W-1:0]        off_full;
    logic [2:0]               off;
    logic                     sel, wr;
    logic                     wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
    logic [DataWidth-1:0]     mlo, mhi, clo, chi, ctrl_raw, ctrl, rdata;
    logic [63:0]              mtime, mtimecmp, mtime_nxt;
    logic [PrescaleWidth-1:0] pcnt_q, pcnt_d, div;
    logic                     en, tick, mtime_upd;
    logic                     irq_q;

    // Unsigned subtraction folds the below-base case into the out-of-window range.
    assign off_full = bus.address - BASE_WORD;
    assign off      = off_full[2:0];
    assign sel      = (off_full < ADDR_W'(WIN_WORDS)) && (bus.read || bus.write) && !bus.intercept;
    assign wr       = sel && bus.write;

    assign wr_mlo  = wr && (off == TIMER_MTIME_LO);
    assign wr_mhi  = wr && (off == TIMER_MTIME_HI);
    assign wr_clo  = wr && (off == TIMER_MTIMECMP_LO);
    assign wr_chi  = wr && (off == TIMER_MTIMECMP_HI);
    assign wr_ctrl = wr && (off == TIMER_CTRL);

    assign ctrl = ctrl_raw & CTRL_MASK;
    assign en   = ctrl[CTRL_EN_BIT];
    assign div  = ctrl[CTRL_DIV_LSB +: PrescaleWidth];
    assign tick = en && (pcnt_q == div);

    assign mtime     = {mhi, mlo};
    assign mtimecmp  = {chi, clo};
    assign mtime_nxt = mtime + 64'd1;
    // A bus write to either half suppresses the increment of both halves.
    assign mtime_upd = tick && !(wr_mlo || wr_mhi);

    arilla_be_reg #(.DataWidth(DataWidth), .ResetVal(MTIME_RST[31:0])) u_mlo (
        .clk(clk), .rst(rst), .we_i(wr_mlo), .be_i(bus.byte_enable), .wdata_i(bus.data_ctp),
        .upd_i(mtime_upd), .nxt_i(mtime_nxt[31:0]), .q_o(mlo));
    arilla_be_reg #(.DataWidth(DataWidth), .ResetVal(MTIME_RST[63:32])) u_mhi (
        .clk(clk), .rst(rst), .we_i(wr_mhi), .be_i(bus.byte_enable), .wdata_i(bus.data_ctp),
        .upd_i(mtime_upd), .nxt_i(mtime_nxt[63:32]), .q_o(mhi));
    arilla_be_reg #(.DataWidth(DataWidth), .ResetVal(MTIMECMP_RST[31:0])) u_clo (
        .clk(clk), .rst(rst), .we_i(wr_clo), .be_i(bus.byte_enable), .wdata_i(bus.data_ctp),
        .upd_i(1'b0), .nxt_i(clo), .q_o(clo));
    arilla_be_reg #(.DataWidth(DataWidth), .ResetVal(MTIMECMP_RST[63:32])) u_chi (
        .clk(clk), .rst(rst), .we_i(wr_chi), .be_i(bus.byte_enable), .wdata_i(bus.data_ctp),
        .upd_i(1'b0), .nxt_i(chi), .q_o(chi));
    arilla_be_reg #(.DataWidth(DataWidth), .ResetVal(CTRL_RST)) u_ctrl (
        .clk(clk), .rst(rst), .we_i(wr_ctrl), .be_i(bus.byte_enable),
        .wdata_i(bus.data_ctp & CTRL_MASK), .upd_i(1'b0), .nxt_i(ctrl_raw), .q_o(ctrl_raw));

    // The >= wrap keeps the prescaler bounded if DIV is lowered below the running count.
    always_comb begin
        pcnt_d = pcnt_q;
        if (wr_ctrl)
            pcnt_d = '0;
        else if (en)
            pcnt_d = (pcnt_q >= div) ? '0 : pcnt_q + {{(PrescaleWidth-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            irq_q  <= (mtime >= mtimecmp);
        end
    end
    assign timer_irq = irq_q;

`ifdef ARILLA_TIMER_MSIP_EN
    logic msip_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 msip_q <= 1'b0;
        else if (wr && (off == TIMER_MSIP) && bus.byte_enable[0]) msip_q <= bus.data_ctp[0];
    end
    assign soft_irq = msip_q;
`endif

    always_comb begin
        rdata = '0;
        case (timer_off_e'(off))
            TIMER_MTIME_LO:    rdata = mlo;
            TIMER_MTIME_HI:    rdata = mhi;
            TIMER_MTIMECMP_LO: rdata = clo;
            TIMER_MTIMECMP_HI: rdata = chi;
            TIMER_CTRL:        rdata = ctrl;
`ifdef ARILLA_TIMER_MSIP_EN
            TIMER_MSIP:        rdata = {{(DataWidth-1){1'b0}}, msip_q};
`endif
            default:           rdata = '0;
        endcase
    end

    assign bus.data_ptc  = sel ? rdata : 'z;
    assign bus.available = sel ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_arilla_timer.sv
// Directed bench for arilla_timer: register table plus hand sequences for counting, irq, bus release.
module tb_arilla_timer;
    localparam logic [29:0] BASE = 30'h0080_0000;

    logic clk, rst, timer_irq;
`ifdef ARILLA_TIMER_MSIP_EN
    logic soft_irq;
`endif
    int checks = 0;
    int errors = 0;

    arilla_bus_if #(.DataWidth(32), .AddrWidth(30)) bus ();

    arilla_timer dut (
        .clk(clk), .rst(rst), .bus(bus),
`ifdef ARILLA_TIMER_MSIP_EN
        .soft_irq(soft_irq),
`endif
        .timer_irq(timer_irq));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  off;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.read = 1'b0; bus.write = 1'b0; bus.intercept = 1'b0;
    endtask

    task automatic do_write(input logic [29:0] addr, input logic [31:0] d, input logic [3:0] be,
                            input logic icpt);
        bus.address = addr; bus.data_ctp = d; bus.byte_enable = be;
        bus.read = 1'b0; bus.write = 1'b1; bus.intercept = icpt;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        do_write(BASE + 30'(off), d, 4'hF, 1'b0);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        bus.address = BASE + 30'(off); bus.read = 1'b1; bus.write = 1'b0; bus.intercept = 1'b0;
        #1;
        d = bus.data_ptc;
        bus.read = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        check(name, d, exp);
    endtask

    vec_t vecs[11];
    logic [31:0] msip_exp;

    initial begin
`ifdef ARILLA_TIMER_MSIP_EN
        msip_exp = 32'h1;
`else
        msip_exp = 32'h0;
`endif
        //          wr    off   data           be       exp
        vecs[0]  = '{1'b0, 3'd3, 32'h0,        4'h0, 32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, 3'd2, 32'h0,        4'h0, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, 3'd0, 32'h0,        4'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'd4, 32'h0,        4'h0, 32'h0};
        vecs[4]  = '{1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, 32'hFFBB_FFDD};
        vecs[5]  = '{1'b1, 3'd2, 32'h1122_3344, 4'b1010, 32'h11BB_33DD};
        vecs[6]  = '{1'b1, 3'd6, 32'h1234_5678, 4'hF, 32'h0};
        vecs[7]  = '{1'b1, 3'd4, 32'hFFFF_FFFE, 4'hF, 32'hFFFF_0000};
        vecs[8]  = '{1'b1, 3'd1, 32'h0000_0123, 4'hF, 32'h0000_0123};
        vecs[9]  = '{1'b1, 3'd5, 32'h0000_0001, 4'hF, msip_exp};
        vecs[10] = '{1'b1, 3'd0, 32'hDEAD_BEEF, 4'h0, 32'h0};

        bus.address = '0; bus.data_ctp = '0; bus.byte_enable = '0;
        idle();
        rst = 1'b1;
        #12 rst = 1'b0;

        check("reset_irq", {31'b0, timer_irq}, 32'h0);
        #1 check("idle_released", {31'b0, bus.available === 1'b1}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) do_write(BASE + 30'(vecs[i].off), vecs[i].data, vecs[i].be, 1'b0);
            rd_chk($sformatf("vec%0d", i), vecs[i].off, vecs[i].exp);
        end

        // DIV=0: one increment per cycle after the enabling write edge
        wr(3'd4, 32'h0); wr(3'd0, 32'h0); wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        repeat (10) @(posedge clk);
        #1 rd_chk("div0_count10", 3'd0, 32'd10);

        // DIV=3: increments at edges 4, 8, 12 after the write
        wr(3'd4, 32'h0); wr(3'd0, 32'h0);
        wr(3'd4, 32'h0003_0001);
        repeat (8) @(posedge clk);
        #1 rd_chk("div3_e8", 3'd0, 32'd2);
        repeat (3) @(posedge clk);
        #1 rd_chk("div3_e11", 3'd0, 32'd2);
        @(posedge clk);
        #1 rd_chk("div3_e12", 3'd0, 32'd3);

        // lo-to-hi carry
        wr(3'd4, 32'h0); wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        @(posedge clk);
        #1 rd_chk("carry_hi", 3'd1, 32'h1);
        rd_chk("carry_lo", 3'd0, 32'h0);

        // timer_irq against mtimecmp=5
        wr(3'd4, 32'h0); wr(3'd2, 32'd5); wr(3'd3, 32'h0); wr(3'd0, 32'h0); wr(3'd1, 32'h0);
        @(posedge clk);
        #1 check("irq_idle_low", {31'b0, timer_irq}, 32'h0);
        wr(3'd4, 32'h1);
        repeat (5) @(posedge clk);
        #1 check("irq_at_eq", {31'b0, timer_irq}, 32'h0);
        @(posedge clk);
        #1 check("irq_rise", {31'b0, timer_irq}, 32'h1);
        wr(3'd3, 32'h1);
        check("irq_hold_at_wr", {31'b0, timer_irq}, 32'h1);
        @(posedge clk);
        #1 check("irq_fall", {31'b0, timer_irq}, 32'h0);

        // mtime write on a tick cycle: write wins, neither half increments
        wr(3'd0, 32'd100);
        wr(3'd1, 32'd7);
        rd_chk("tickwr_lo", 3'd0, 32'd100);
        rd_chk("tickwr_hi", 3'd1, 32'd7);

        // intercept and out-of-window accesses are ignored and release the bus
        wr(3'd4, 32'h0);
        bus.address = BASE + 30'd2; bus.data_ctp = 32'h1111_1111; bus.byte_enable = 4'hF;
        bus.write = 1'b1; bus.intercept = 1'b1;
        #1 check("icpt_released", {31'b0, bus.available === 1'b1}, 32'h0);
        @(posedge clk); #1 idle();
        rd_chk("icpt_nochg", 3'd2, 32'd5);
        bus.address = BASE + 30'd10; bus.write = 1'b1;
        #1 check("oow_hi_released", {31'b0, bus.available === 1'b1}, 32'h0);
        @(posedge clk); #1 idle();
        bus.address = BASE - 30'd1; bus.read = 1'b1;
        #1 check("oow_lo_released", {31'b0, bus.available === 1'b1}, 32'h0);
        idle();
        rd_chk("oow_nochg", 3'd2, 32'd5);

        // read+write together: returns pre-write value, then the write lands
        bus.address = BASE + 30'd2; bus.data_ctp = 32'h0000_00A5; bus.byte_enable = 4'hF;
        bus.read = 1'b1; bus.write = 1'b1;
        #1 check("rw_prewrite", bus.data_ptc, 32'd5);
        check("rw_avail", {31'b0, bus.available === 1'b1}, 32'h1);
        @(posedge clk); #1 idle();
        rd_chk("rw_written", 3'd2, 32'hA5);

`ifdef ARILLA_TIMER_MSIP_EN
        wr(3'd5, 32'h0);
        check("msip_clr", {31'b0, soft_irq}, 32'h0);
        wr(3'd5, 32'h1);
        check("msip_set", {31'b0, soft_irq}, 32'h1);
`endif

        // async reset in the middle of a write
        wr(3'd3, 32'h0);
        @(posedge clk);
        #1 check("irq_pre_reset", {31'b0, timer_irq}, 32'h1);
        bus.address = BASE + 30'd2; bus.data_ctp = 32'h0; bus.byte_enable = 4'hF; bus.write = 1'b1;
        #2 rst = 1'b1;
        #1 idle();
        check("rst_irq", {31'b0, timer_irq}, 32'h0);
        rd_chk("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd_chk("rst_mtime_hi", 3'd1, 32'h0);
        rd_chk("rst_ctrl", 3'd4, 32'h0);
`ifdef ARILLA_TIMER_MSIP_EN
        check("rst_soft_irq", {31'b0, soft_irq}, 32'h0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rd_chk("post_rst_frozen", 3'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
